// File: rtl/spi_cmd_decoder_if.sv
// Byte-in / command-out bundle between the SPI byte assembler, the command
// decoder and the command-execution logic.
interface spi_cmd_decoder_if;
  logic        CS;
  logic [7:0]  Buffer;
  logic        Changed;
  logic [5:0]  CmdIndex;
  logic [31:0] Arg;
  logic        CmdValid;
  logic        CrcError;
  logic        FrameError;
  logic        Busy;
  logic [7:0]  CmdCount;

  modport master (
    output CS, Buffer, Changed,
    input  CmdIndex, Arg, CmdValid, CrcError, FrameError, Busy, CmdCount
  );

  modport slave (
    input  CS, Buffer, Changed,
    output CmdIndex, Arg, CmdValid, CrcError, FrameError, Busy, CmdCount
  );
endinterface

// File: rtl/spi_cmd_decoder.sv
// Frames 6-byte SD-style command packets from the SPI byte stream, checks the
// end bit and CRC7, and publishes accepted commands with a one-cycle strobe.
module spi_cmd_decoder #(
  parameter bit         CHECK_CRC = 1'b1,
  parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
  input logic           CLK,
  input logic           RST_N,
  spi_cmd_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARG  = 2'd1,
    ST_CRC  = 2'd2
  } stateT;

  // CRC7 (x^7 + x^3 + 1), one whole byte per call, MSB first.
  function automatic logic [6:0] crc7Update(input logic [6:0] crcIn, input logic [7:0] data);
    logic [6:0] c;
    logic       fb;
    c = crcIn;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ data[i];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  stateT       stateR;
  stateT       stateNxtS;
  logic [5:0]  shadowIdxR;
  logic [31:0] shadowArgR;
  logic [6:0]  crcR;
  logic [1:0]  byteCntR;
  logic [5:0]  cmdIndexR;
  logic [31:0] argR;
  logic        cmdValidR;
  logic        crcErrR;
  logic        frameErrR;
  logic        busyR;
  logic [7:0]  cmdCountR;

  logic        takeS;
  logic        startS;
  logic [6:0]  crcNextS;
  logic        crcOkS;
  logic        cmdValidNxtS;
  logic        crcErrNxtS;
  logic        frameErrNxtS;

  // A deselected chip drops the byte even when Changed coincides with CS high.
  assign takeS    = bus.Changed & ~bus.CS;
  assign startS   = (bus.Buffer[7:6] == 2'b01) && (bus.Buffer != IDLE_BYTE);
  assign crcNextS = crc7Update((stateR == ST_IDLE) ? 7'd0 : crcR, bus.Buffer);
  assign crcOkS   = (bus.Buffer[7:1] == crcR) || (CHECK_CRC == 1'b0);

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stateR <= ST_IDLE;
    end else begin
      stateR <= stateNxtS;
    end
  end

  // Next-state logic.
  always_comb begin
    stateNxtS = stateR;
    if (bus.CS) begin
      stateNxtS = ST_IDLE;
    end else if (bus.Changed) begin
      case (stateR)
        ST_IDLE: stateNxtS = startS ? ST_ARG : ST_IDLE;
        ST_ARG:  stateNxtS = (byteCntR == 2'd3) ? ST_CRC : ST_ARG;
        ST_CRC:  stateNxtS = ST_IDLE;
        default: stateNxtS = ST_IDLE;
      endcase
    end else begin
      stateNxtS = stateR;
    end
  end

  // Frame verdict on the closing byte; end-bit failure takes priority over CRC.
  always_comb begin
    cmdValidNxtS = 1'b0;
    crcErrNxtS   = 1'b0;
    frameErrNxtS = 1'b0;
    if (takeS && (stateR == ST_CRC)) begin
      if (!bus.Buffer[0]) begin
        frameErrNxtS = 1'b1;
      end else if (!crcOkS) begin
        crcErrNxtS = 1'b1;
      end else begin
        cmdValidNxtS = 1'b1;
      end
    end else begin
      cmdValidNxtS = 1'b0;
      crcErrNxtS   = 1'b0;
      frameErrNxtS = 1'b0;
    end
  end

  // Shadow capture, CRC accumulation and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shadowIdxR <= 6'd0;
      shadowArgR <= 32'd0;
      crcR       <= 7'd0;
      byteCntR   <= 2'd0;
      cmdIndexR  <= 6'd0;
      argR       <= 32'd0;
      cmdValidR  <= 1'b0;
      crcErrR    <= 1'b0;
      frameErrR  <= 1'b0;
      busyR      <= 1'b0;
      cmdCountR  <= 8'd0;
    end else begin
      cmdValidR <= cmdValidNxtS;
      crcErrR   <= crcErrNxtS;
      frameErrR <= frameErrNxtS;
      busyR     <= (stateNxtS != ST_IDLE);

      if (bus.CS) begin
        shadowIdxR <= 6'd0;
        shadowArgR <= 32'd0;
        crcR       <= 7'd0;
        byteCntR   <= 2'd0;
      end else if (bus.Changed) begin
        case (stateR)
          ST_IDLE: begin
            if (startS) begin
              shadowIdxR <= bus.Buffer[5:0];
              shadowArgR <= 32'd0;
              crcR       <= crcNextS;
              byteCntR   <= 2'd0;
            end else begin
              crcR     <= 7'd0;
              byteCntR <= 2'd0;
            end
          end
          ST_ARG: begin
            shadowArgR <= {shadowArgR[23:0], bus.Buffer};
            crcR       <= crcNextS;
            byteCntR   <= byteCntR + 2'd1;
          end
          ST_CRC: begin
            crcR     <= 7'd0;
            byteCntR <= 2'd0;
          end
          default: begin
            crcR     <= 7'd0;
            byteCntR <= 2'd0;
          end
        endcase
      end else begin
        byteCntR <= byteCntR;
      end

      if (cmdValidNxtS) begin
        cmdIndexR <= shadowIdxR;
        argR      <= shadowArgR;
        cmdCountR <= cmdCountR + 8'd1;
      end else begin
        cmdCountR <= cmdCountR;
      end
    end
  end

  assign bus.CmdIndex   = cmdIndexR;
  assign bus.Arg        = argR;
  assign bus.CmdValid   = cmdValidR;
  assign bus.CrcError   = crcErrR;
  assign bus.FrameError = frameErrR;
  assign bus.Busy       = busyR;
  assign bus.CmdCount   = cmdCountR;

endmodule

// File: doc/spi_cmd_decoder.md
Name: spi_cmd_decoder

Overview:
Downstream consumer of the SPI byte assembler. Takes each completed byte (byte bus plus new-byte strobe) and frames 6-byte SD-style command packets: a start/index byte, a 4-byte big-endian argument, and a CRC7/end byte. Checks framing and CRC7, then presents the command index and argument with a one-cycle valid strobe to the command-execution logic. Runs in the SPI clock domain.

Parameters:
CHECK_CRC, 1, 1 = CRC7 mismatch raises CrcError and suppresses CmdValid; 0 = CRC byte is accepted without a CRC7 check (end bit still checked).
IDLE_BYTE, 8'hFF, byte value ignored while waiting for a start byte.

Ports:
CLK  in  1  SPI clock; all logic on rising edge.
RST_N  in  1  asynchronous active-low reset.
CS  in  1  chip select, active low; high = deselected, aborts any frame.
Buffer  in  8  completed byte from the assembler, valid when Changed=1.
Changed  in  1  one-CLK-cycle strobe: Buffer holds a new complete byte.
CmdIndex  out  6  index of last accepted command.
Arg  out  32  argument of last accepted command, first argument byte in [31:24].
CmdValid  out  1  one-cycle pulse: CmdIndex/Arg updated with a good frame.
CrcError  out  1  one-cycle pulse: frame complete, CRC7 mismatch.
FrameError  out  1  one-cycle pulse: frame complete, end bit (bit0 of byte 6) = 0.
Busy  out  1  high while a frame is partially received.
CmdCount  out  8  count of accepted commands; wraps 255->0.

Behaviour:
- Reset (async, RST_N=0): state IDLE; CmdIndex=0, Arg=0, CmdValid=CrcError=FrameError=0, Busy=0, CmdCount=0, CRC accumulator=0, byte counter=0.
- Only bytes with Changed=1 and CS=0 are consumed. All other cycles hold state.
- States:
  - IDLE: a byte with Buffer[7:6]=2'b01 is a start byte. Latch Buffer[5:0] into a shadow index, seed CRC7 with the byte, and go to ARG with counter=0. IDLE_BYTE and any other byte are ignored silently.
  - ARG: shift the byte into the shadow argument (MSB byte first) and update CRC7. After the 4th byte go to CRC.
  - CRC: compare Buffer[7:1] with the accumulated CRC7, check Buffer[0]=1, then return to IDLE.
- CRC7: polynomial x^7+x^3+1, initial 0, computed MSB-first over bytes 1-5. The per-byte update must be combinational, with no extra cycles.
- Result, registered on the cycle after the 6th byte's Changed:
  - end bit 0: FrameError=1, no update.
  - else CRC mismatch with CHECK_CRC=1: CrcError=1, no update.
  - else: CmdIndex/Arg loaded from shadow, CmdValid=1, CmdCount+1.
  - Exactly one of the three pulses fires per completed frame; each is high for exactly one cycle.
- Busy=1 in ARG and CRC states, 0 in IDLE.
- Outputs CmdIndex/Arg hold until the next accepted frame; failed frames never disturb them.
- CS=1 in any cycle: return to IDLE immediately, discard shadow registers. No error pulse.
- CS=1 coinciding with Changed: CS wins and the byte is dropped.
- A start-pattern byte arriving in ARG/CRC is treated as data; there is no resync mid-frame.
- Changed on consecutive cycles must be handled (one byte per cycle throughput).
- Reset mid-frame: frame discarded, all outputs to reset values asynchronously.

Test Plan:
1. CS=0; bytes 40 00 00 00 00 95 -> one cycle after the last byte, CmdValid=1, CmdIndex=0, Arg=0, CmdCount=1, no error pulses.
2. Bytes 48 00 00 01 AA 87 -> CmdValid, CmdIndex=8, Arg=32'h000001AA.
3. Bytes 48 00 00 01 AA 89 -> CrcError pulse only; CmdIndex/Arg still hold the previous values. Repeat with CHECK_CRC=0 -> CmdValid instead.
4. Bytes 40 00 00 00 00 94 -> FrameError pulse only; with FF FF before the start byte, the FF bytes are ignored and Busy stays 0 until the 40 arrives.
5. Send 48 00 00, then CS=1 for 2 cycles, then CS=0 and a full CMD0 frame -> no pulse at the abort; CMD0 is accepted. Repeat with RST_N pulsed low mid-frame -> all outputs 0, next frame accepted.
6. 256 back-to-back CMD0 frames with Changed every cycle -> 256 CmdValid pulses; CmdCount wraps to 0.
